// File: rtl/mul_scheduler_if.sv
// -----------------------------------------------------------------------------
// mul_scheduler_if
//
// Bundles every signal of the multiplier scheduler except clk and rst_n:
//   - request side   : Req_Valid, Req_A, Req_B, Req_Ready
//   - multiplier side: Mul_A, Mul_B (to the multiplier), Mul_S, Mul_Overflow
//   - response side  : Rsp_Valid, Rsp_Ready, Rsp_Id, Rsp_S, Rsp_Overflow
//   - status         : Busy
//
// Modports
//   slave  : the scheduler itself.
//   master : its environment, meaning the two requesters, the consumer of the
//            response channel and the combinational multiplier instance.
//
// Parameter
//   l : operand/result width. It must match the multiplier instance and the
//       l parameter of the scheduler.
// -----------------------------------------------------------------------------
interface mul_scheduler_if #(
  parameter int l = 16
);

  // Requester i uses bit i of the valid/ready vectors and lane [i*l +: l].
  logic [1:0]     Req_Valid;
  logic [2*l-1:0] Req_A;
  logic [2*l-1:0] Req_B;
  logic [1:0]     Req_Ready;

  // Registered operands into the shared multiplier, and its outputs.
  logic [l-1:0]   Mul_A;
  logic [l-1:0]   Mul_B;
  logic [l-1:0]   Mul_S;
  logic           Mul_Overflow;

  // Shared response channel. Rsp_Id is the requester the result belongs to.
  logic           Rsp_Valid;
  logic           Rsp_Ready;
  logic           Rsp_Id;
  logic [l-1:0]   Rsp_S;
  logic           Rsp_Overflow;

  logic           Busy;

  modport slave (
    input  Req_Valid, Req_A, Req_B, Mul_S, Mul_Overflow, Rsp_Ready,
    output Req_Ready, Mul_A, Mul_B, Rsp_Valid, Rsp_Id, Rsp_S, Rsp_Overflow,
           Busy
  );

  modport master (
    output Req_Valid, Req_A, Req_B, Mul_S, Mul_Overflow, Rsp_Ready,
    input  Req_Ready, Mul_A, Mul_B, Rsp_Valid, Rsp_Id, Rsp_S, Rsp_Overflow,
           Busy
  );

endinterface : mul_scheduler_if

// File: rtl/mul_scheduler.sv
// -----------------------------------------------------------------------------
// mul_scheduler
//
// Shares one combinational multiplier between two requesters. It arbitrates
// round-robin and registers the winning operands onto the multiplier inputs.
// It then gives the long multiplier path SETTLE cycles before it samples the
// product. The captured result is returned on a shared response channel, tagged
// with the id of the requester that issued it.
//
// Operation flow: IDLE -> (accept) -> WAIT -> (counter expires) -> RESP ->
// (Rsp_Ready) -> IDLE. Only one operation is in flight at a time.
//
// Ports
//   clk          : system clock; single clock domain.
//   rst_n        : synchronous active-low reset.
//   bus          : mul_scheduler_if.slave. It carries the requests, the
//                  multiplier operands and results, the response channel and
//                  Busy.
//   Stat_Clear   : (stats build only) clears both statistics counters.
//   Op_Count     : (stats build only) completed response handshakes, saturating.
//   Ovf_Count    : (stats build only) handshakes whose Rsp_Overflow was set,
//                  saturating.
//
// Parameters
//   l      : operand/result width. It must match the multiplier and the
//            interface.
//   SETTLE : cycles from operand register to result sample, legal range 1..15.
//
// Optional feature
//   MUL_SCHED_STATS_EN : when defined, adds the Stat_Clear / Op_Count /
//   Ovf_Count statistics ports and counters. When undefined, they are absent.
// -----------------------------------------------------------------------------
module mul_scheduler #(
  parameter int l      = 16,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MUL_SCHED_STATS_EN
  input  logic                 Stat_Clear,
  output logic [15:0]          Op_Count,
  output logic [15:0]          Ovf_Count,
`endif
  mul_scheduler_if.slave       bus
);

  // 4 bits is enough for the largest legal preload value, SETTLE-1 = 14.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;

  logic           last_q;        // last requester served (round-robin pointer)
  logic [3:0]     cnt_q;         // settle countdown while in WAIT
  logic [l-1:0]   mul_a_q, mul_b_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [l-1:0]   rsp_s_q;
  logic           rsp_ovf_q;

  logic           grant_vld;
  logic           grant_id;
  logic [1:0]     req_ready;
  logic           accept;        // request handshake on this edge
  logic           capture;       // multiplier output sampled on this edge
  logic           rsp_done;      // response handshake on this edge

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. A lone requester always wins. On a tie, the
  // requester that was not served last wins, so a loser that holds its
  // request is guaranteed the next slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default before any branch.
    // An unassigned path in a combinational block would infer a latch.
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (bus.Req_Valid)
      2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;    end
      2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;    end
      2'b11:   begin grant_vld = 1'b1; grant_id = ~last_q; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // Requests are re-arbitrated on every IDLE cycle. A request that is
        // dropped before it is granted leaves no trace.
        if (grant_vld) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE costs a cycle. A new operation is therefore never
        // accepted on the same edge as the response handshake.
        if (bus.Rsp_Ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge, whatever the order
    // of the statements.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. A reset in mid-operation discards the operation:
  // no response is ever produced for it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= 1'b1;       // requester 0 wins the first tie
      cnt_q       <= 4'd0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        // Mul_A/Mul_B then hold these operands until the next accept. They
        // are not cleared when the operation completes.
        mul_a_q  <= grant_id ? bus.Req_A[2*l-1:l] : bus.Req_A[l-1:0];
        mul_b_q  <= grant_id ? bus.Req_B[2*l-1:l] : bus.Req_B[l-1:0];
        rsp_id_q <= grant_id;
        last_q   <= grant_id;
        cnt_q    <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (capture) begin
        rsp_s_q     <= bus.Mul_S;
        rsp_ovf_q   <= bus.Mul_Overflow;
        rsp_valid_q <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.Req_Ready    = req_ready;
  assign bus.Mul_A        = mul_a_q;
  assign bus.Mul_B        = mul_b_q;
  assign bus.Rsp_Valid    = rsp_valid_q;
  assign bus.Rsp_Id       = rsp_id_q;
  assign bus.Rsp_S        = rsp_s_q;
  assign bus.Rsp_Overflow = rsp_ovf_q;
  assign bus.Busy         = (state_q != IDLE);

`ifdef MUL_SCHED_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: count completed response handshakes, and the overflowed ones
  // among them. Both counters saturate at all-ones. Stat_Clear takes priority
  // over an increment on the same edge.
  // ---------------------------------------------------------------------------
  logic [15:0] op_cnt_q, ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || Stat_Clear) begin
      op_cnt_q  <= 16'd0;
      ovf_cnt_q <= 16'd0;
    end else if (rsp_done) begin
      if (op_cnt_q != 16'hFFFF)
        op_cnt_q <= op_cnt_q + 16'd1;
      if (rsp_ovf_q && ovf_cnt_q != 16'hFFFF)
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign Op_Count  = op_cnt_q;
  assign Ovf_Count = ovf_cnt_q;
`endif

endmodule : mul_scheduler

// File: tb/tb_mul_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mul_scheduler
//
// Self-checking bench for mul_scheduler. A behavioural signed multiplier sits
// on the Mul_* side as the golden multiplication instance. The bench covers:
//   - the reset state;
//   - a table of single-requester operations;
//   - hand-written sequences for contention, backpressure and reset in
//     mid-operation;
//   - the statistics counters, when MUL_SCHED_STATS_EN is defined;
//   - a randomized run checked every cycle against a transaction-level
//     reference model.
// The SETTLE value is 2 in the default build and 1 in the stats build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mul_scheduler;

  localparam int l = 16;
`ifdef MUL_SCHED_STATS_EN
  localparam int SETTLE = 1;
`else
  localparam int SETTLE = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_scheduler_if #(.l(l)) bus ();

`ifdef MUL_SCHED_STATS_EN
  logic        stat_clear;
  logic [15:0] op_count, ovf_count;
  bit          clr_at_rsp;
`endif

  mul_scheduler #(.l(l), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MUL_SCHED_STATS_EN
    .Stat_Clear (stat_clear),
    .Op_Count   (op_count),
    .Ovf_Count  (ovf_count),
`endif
    .bus        (bus)
  );

  // Golden multiplier: signed l-bit operands. S is the low l bits of the
  // exact product, and Overflow is set when the product does not fit in l
  // signed bits.
  function automatic logic [l:0] mul_ref(input logic [l-1:0] a, input logic [l-1:0] b);
    longint p, lim;
    logic [63:0] pv;
    p   = longint'($signed(a)) * longint'($signed(b));
    lim = longint'(1) <<< (l - 1);
    pv  = p;
    return {(p >= lim) || (p < -lim), pv[l-1:0]};
  endfunction

  always_comb {bus.Mul_Overflow, bus.Mul_S} = mul_ref(bus.Mul_A, bus.Mul_B);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.Req_Valid = 2'b00;
    bus.Req_A     = '0;
    bus.Req_B     = '0;
    bus.Rsp_Ready = 1'b0;
`ifdef MUL_SCHED_STATS_EN
    stat_clear    = 1'b0;
    clr_at_rsp    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Issues one operation and follows it to the response handshake. The task
  // is entered just after a negedge and also returns just after a negedge.
  // With hold set, Req_Valid stays asserted afterwards.
  task automatic do_op(input string nm, input logic [1:0] v,
                       input logic [l-1:0] a0, input logic [l-1:0] b0,
                       input logic [l-1:0] a1, input logic [l-1:0] b1,
                       input bit hold, input logic exp_id,
                       input logic [l-1:0] exp_s, input logic exp_ovf);
    int k;
    bit rr_seen;
    bus.Req_Valid = v;
    bus.Req_A     = {a1, a0};
    bus.Req_B     = {b1, b0};
    bus.Rsp_Ready = 1'b1;
    #1;
    k = 0;
    while (bus.Req_Ready == 2'b00 && k < 50) begin @(negedge clk); #1; k++; end
    check({nm, "_accept_in_time"}, 64'(k < 50), 64'd1);
    check({nm, "_req_ready"}, 64'(bus.Req_Ready), exp_id ? 64'h2 : 64'h1);
    @(negedge clk);                        // the accept edge has passed
    if (!hold) bus.Req_Valid = 2'b00;
    #1;
    check({nm, "_busy"}, 64'(bus.Busy), 64'd1);
    // Rsp_Valid is expected on the SETTLE-th edge after the accept edge.
    k = 0;
    rr_seen = 1'b0;
    while (!bus.Rsp_Valid && k < 50) begin
      if (bus.Req_Ready != 2'b00) rr_seen = 1'b1;
      @(negedge clk); #1; k++;
    end
    check({nm, "_latency"}, 64'(k), 64'(SETTLE));
    check({nm, "_no_ready_while_busy"}, 64'(rr_seen), 64'd0);
    check({nm, "_rsp_id"}, 64'(bus.Rsp_Id), 64'(exp_id));
    check({nm, "_rsp_s"}, 64'(bus.Rsp_S), 64'(exp_s));
    check({nm, "_rsp_ovf"}, 64'(bus.Rsp_Overflow), 64'(exp_ovf));
    check({nm, "_mul_a"}, 64'(bus.Mul_A), 64'(exp_id ? a1 : a0));
`ifdef MUL_SCHED_STATS_EN
    stat_clear = clr_at_rsp;
`endif
    @(negedge clk);                        // response handshake edge has passed
`ifdef MUL_SCHED_STATS_EN
    stat_clear = 1'b0;
`endif
    #1;
    check({nm, "_rsp_valid_low"}, 64'(bus.Rsp_Valid), 64'd0);
    check({nm, "_idle"}, 64'(bus.Busy), 64'd0);
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [l-1:0] a, b;
    logic         exp_id;
    logic [l-1:0] exp_s;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [l:0] r0, r1;
    logic [l-1:0] ca0, cb0, ca1, cb1;
    bit seen;
    int k;

    // Signed-product expectations, worked out by hand.
    vecs[0] = '{2'b01, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0};
    vecs[1] = '{2'b10, 16'h7FFF, 16'h0002, 1'b1, 16'hFFFE, 1'b1};
    vecs[2] = '{2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b0};
    vecs[3] = '{2'b10, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{2'b01, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1};
    vecs[5] = '{2'b10, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b0};
    vecs[6] = '{2'b01, 16'hFFFE, 16'h0003, 1'b0, 16'hFFFA, 1'b0};
    vecs[7] = '{2'b10, 16'h00FF, 16'h0080, 1'b1, 16'h7F80, 1'b0};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_req_ready", 64'(bus.Req_Ready), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
    check("rst_rsp_id", 64'(bus.Rsp_Id), 64'd0);
    check("rst_rsp_s", 64'(bus.Rsp_S), 64'd0);
    check("rst_rsp_ovf", 64'(bus.Rsp_Overflow), 64'd0);
    check("rst_mul_a", 64'(bus.Mul_A), 64'd0);
    check("rst_mul_b", 64'(bus.Mul_B), 64'd0);

`ifndef MUL_SCHED_STATS_EN
    // ---------------- table of single-requester operations ----------------
    // The lane that is not requesting carries random junk, which would
    // expose a wrong lane being selected.
    for (int i = 0; i < 8; i++) begin
      ca0 = 16'($urandom); cb0 = 16'($urandom);
      if (vecs[i].v == 2'b01)
        do_op($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].b, ca0, cb0,
              1'b0, vecs[i].exp_id, vecs[i].exp_s, vecs[i].exp_ovf);
      else
        do_op($sformatf("vec%0d", i), vecs[i].v, ca0, cb0, vecs[i].a, vecs[i].b,
              1'b0, vecs[i].exp_id, vecs[i].exp_s, vecs[i].exp_ovf);
    end
    // Operands are held after completion.
    check("mul_b_held", 64'(bus.Mul_B), 64'h0080);

    // ---------------- contention: grant order 0, 1, 0 ----------------
    do_reset();
    ca0 = 16'h1234; cb0 = 16'h0003; ca1 = 16'h0FFF; cb1 = 16'h0011;
    r0 = mul_ref(ca0, cb0);
    r1 = mul_ref(ca1, cb1);
    do_op("tie0", 2'b11, ca0, cb0, ca1, cb1, 1'b1, 1'b0, r0[l-1:0], r0[l]);
    do_op("tie1", 2'b11, ca0, cb0, ca1, cb1, 1'b1, 1'b1, r1[l-1:0], r1[l]);
    do_op("tie2", 2'b11, ca0, cb0, ca1, cb1, 1'b1, 1'b0, r0[l-1:0], r0[l]);
    bus.Req_Valid = 2'b00;

    // ---------------- backpressure ----------------
    @(negedge clk);
    ca0 = 16'h4000; cb0 = 16'h0004;        // overflowing product
    r0 = mul_ref(ca0, cb0);
    bus.Req_Valid = 2'b01;
    bus.Req_A = {16'h0007, ca0};
    bus.Req_B = {16'h0009, cb0};
    bus.Rsp_Ready = 1'b0;
    #1;
    check("bp_accept", 64'(bus.Req_Ready), 64'h1);
    @(negedge clk);
    bus.Req_Valid = 2'b11;                 // both requesters wait throughout
    #1;
    k = 0;
    while (!bus.Rsp_Valid && k < 50) begin @(negedge clk); #1; k++; end
    check("bp_latency", 64'(k), 64'(SETTLE));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("bp_valid_c%0d", c), 64'(bus.Rsp_Valid), 64'd1);
      check($sformatf("bp_s_c%0d", c), 64'(bus.Rsp_S), 64'(r0[l-1:0]));
      check($sformatf("bp_ovf_c%0d", c), 64'(bus.Rsp_Overflow), 64'(r0[l]));
      check($sformatf("bp_id_c%0d", c), 64'(bus.Rsp_Id), 64'd0);
      check($sformatf("bp_ready_c%0d", c), 64'(bus.Req_Ready), 64'd0);
    end
    bus.Rsp_Ready = 1'b1;
    @(negedge clk); #1;
    check("bp_idle", 64'(bus.Busy), 64'd0);
    check("bp_valid_low", 64'(bus.Rsp_Valid), 64'd0);
    check("bp_next_tie_to_1", 64'(bus.Req_Ready), 64'h2);
    bus.Req_Valid = 2'b00;                 // withdrawn before that edge: no accept
    @(negedge clk); #1;
    check("bp_withdrawn", 64'(bus.Busy), 64'd0);

    // ---------------- reset mid-WAIT ----------------
    bus.Req_Valid = 2'b01;
    bus.Req_A = {16'h0001, 16'h0055};
    bus.Req_B = {16'h0001, 16'h0003};
    #1;
    check("mr_accept", 64'(bus.Req_Ready), 64'h1);
    @(negedge clk);
    bus.Req_Valid = 2'b00;
    #1;
    check("mr_in_wait", 64'(bus.Busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_idle", 64'(bus.Busy), 64'd0);
    check("mr_rsp_valid", 64'(bus.Rsp_Valid), 64'd0);
    check("mr_mul_a", 64'(bus.Mul_A), 64'd0);
    check("mr_mul_b", 64'(bus.Mul_B), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < SETTLE + 6; c++) begin
      @(negedge clk); #1;
      if (bus.Rsp_Valid) seen = 1'b1;
    end
    check("mr_no_response", 64'(seen), 64'd0);
    // Requester 0 was served before the reset. The pointer must be back at 1,
    // so requester 0 wins the tie again.
    ca0 = 16'h0011; cb0 = 16'h0011; ca1 = 16'h0022; cb1 = 16'h0022;
    r0 = mul_ref(ca0, cb0);
    do_op("mr_tie", 2'b11, ca0, cb0, ca1, cb1, 1'b0, 1'b0, r0[l-1:0], r0[l]);
`else
    // ---------------- statistics ----------------
    for (int i = 0; i < 3; i++) begin
      ca0 = 16'($urandom); cb0 = 16'($urandom);
      if (vecs[i].v == 2'b01)
        do_op($sformatf("st%0d", i), vecs[i].v, vecs[i].a, vecs[i].b, ca0, cb0,
              1'b0, vecs[i].exp_id, vecs[i].exp_s, vecs[i].exp_ovf);
      else
        do_op($sformatf("st%0d", i), vecs[i].v, ca0, cb0, vecs[i].a, vecs[i].b,
              1'b0, vecs[i].exp_id, vecs[i].exp_s, vecs[i].exp_ovf);
    end
    check("st_op_count", 64'(op_count), 64'd3);
    check("st_ovf_count", 64'(ovf_count), 64'd1);
    clr_at_rsp = 1'b1;
    do_op("st_clr", vecs[1].v, 16'h0, 16'h0, vecs[1].a, vecs[1].b,
          1'b0, vecs[1].exp_id, vecs[1].exp_s, vecs[1].exp_ovf);
    clr_at_rsp = 1'b0;
    check("st_op_cleared", 64'(op_count), 64'd0);
    check("st_ovf_cleared", 64'(ovf_count), 64'd0);
`endif

    // ---------------- randomized run vs transaction-level model ----------------
    do_reset();
    begin
      bit           m_busy = 1'b0;  // an operation has been accepted, response not yet taken
      bit           m_rv   = 1'b0;  // the response is being offered
      int           m_age  = 0;     // edges since the accept
      bit           m_last = 1'b1;
      bit           m_id   = 1'b0;
      logic [l:0]   m_res  = '0;
      logic [1:0]   exp_rr;
      bit           g_vld, g_id;
      logic [l-1:0] ra[2], rb[2];
`ifdef MUL_SCHED_STATS_EN
      int           m_op = 0, m_ovf = 0;
`endif
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
          ra[j] = 16'($urandom) >> $urandom_range(0, 15);
          rb[j] = 16'($urandom) >> $urandom_range(0, 15);
        end
        bus.Req_Valid = 2'($urandom_range(0, 3));
        bus.Req_A     = {ra[1], ra[0]};
        bus.Req_B     = {rb[1], rb[0]};
        bus.Rsp_Ready = ($urandom_range(0, 3) != 0);
`ifdef MUL_SCHED_STATS_EN
        stat_clear    = ($urandom_range(0, 15) == 0);
`endif
        #1;
        g_vld = (bus.Req_Valid != 2'b00);
        g_id  = (bus.Req_Valid == 2'b11) ? !m_last : bus.Req_Valid[1];
        exp_rr = (!m_busy && g_vld) ? (g_id ? 2'b10 : 2'b01) : 2'b00;
        check("rnd_req_ready", 64'(bus.Req_Ready), 64'(exp_rr));
        check("rnd_busy", 64'(bus.Busy), 64'(m_busy));
        check("rnd_rsp_valid", 64'(bus.Rsp_Valid), 64'(m_rv));
        if (m_rv) begin
          check("rnd_rsp_id", 64'(bus.Rsp_Id), 64'(m_id));
          check("rnd_rsp_s", 64'(bus.Rsp_S), 64'(m_res[l-1:0]));
          check("rnd_rsp_ovf", 64'(bus.Rsp_Overflow), 64'(m_res[l]));
        end
`ifdef MUL_SCHED_STATS_EN
        check("rnd_op_count", 64'(op_count), 64'(m_op));
        check("rnd_ovf_count", 64'(ovf_count), 64'(m_ovf));
        if (stat_clear) begin
          m_op = 0; m_ovf = 0;
        end else if (m_rv && bus.Rsp_Ready) begin
          if (m_op < 65535) m_op++;
          if (m_res[l] && m_ovf < 65535) m_ovf++;
        end
`endif
        // Advance the model across the coming edge.
        if (!m_busy) begin
          if (g_vld) begin
            m_busy = 1'b1; m_age = 0; m_id = g_id; m_last = g_id;
            m_res  = mul_ref(ra[g_id], rb[g_id]);
          end
        end else if (!m_rv) begin
          m_age++;
          if (m_age == SETTLE) m_rv = 1'b1;
        end else if (bus.Rsp_Ready) begin
          m_rv = 1'b0; m_busy = 1'b0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mul_scheduler
